fa4_seq_ctrl: RTL



---
 rtl/fa4_seq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fa4_seq_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit ripple slice, one nibble per clock, LSB nibble first.
// Optional subtract mode enabled by defining FA4_SEQ_SUB_EN.
module fa4_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef FA4_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] slice_sum;
    logic       slice_cout;
    logic [4:0] rc;

    // Single 4-bit ripple slice built from full-adder cells.
    always_comb begin
        rc        = '0;
        rc[0]     = carry_q;
        slice_sum = '0;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = opa_q[i] ^ opb_q[i] ^ rc[i];
            rc[i+1]      = (opa_q[i] & opb_q[i]) | (rc[i] & (opa_q[i] ^ opb_q[i]));
        end
        slice_cout = rc[4];
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef FA4_SEQ_SUB_EN
                    // Two's-complement subtract: invert b and inject a carry of one.
                    if (sub) begin
                        opb_d   = ~b;
                        carry_d = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                res_d   = {slice_sum, res_q[WIDTH-1:4]};
                opa_d   = {4'b0000, opa_q[WIDTH-1:4]};
                opb_d   = {4'b0000, opb_q[WIDTH-1:4]};
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    sum_d   = res_d;
                    cout_d  = slice_cout;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule
